button_debouncer: RTL
=====================

# button_debouncer

Multi-channel push-button conditioner for the Basys3 ALU designs. It synchronises raw, bouncing button inputs to `i_clock`, filters bounces with per-channel stability counters, and produces clean debounced levels plus single-cycle press/release pulses. `o_press` drives the load-strobe inputs (A, B, Op) of the downstream `alu_input_ctrl` stage, so each physical press loads its register exactly once.

## Interface

Parameters:
- `N_BTN`, default 3: number of button channels (bit 0 = A, 1 = B, 2 = Op).
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a change (10 ms at 100 MHz). Minimum 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W > DB_CYCLES-1.

Ports:
- `i_clock`, in, 1: system clock. All logic is on its rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset. A 0 clears all state immediately.
- `i_btn`, in, N_BTN: raw asynchronous button levels, 1 = pressed.
- `o_level`, out, N_BTN: debounced button state.
- `o_press`, out, N_BTN: one-cycle pulse on each accepted 0→1 transition.
- `o_release`, out, N_BTN: one-cycle pulse on each accepted 1→0 transition.

## Operation

Each channel i is identical and fully independent.
- **Synchroniser:** two flops, `sync1[i] <= i_btn[i]` and `sync2[i] <= sync1[i]`. Only `sync2` is used downstream.
- **State:** `stable[i]` (equals `o_level[i]`) and `cnt[i]` (CNT_W bits).
- **Update rule, per edge:**
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Pulses:** `o_press` and `o_release` are registered.
  - `o_press[i] <= 1` on exactly the edge where `stable` goes 0→1, else 0.
  - `o_release[i] <= 1` on exactly the edge where `stable` goes 1→0, else 0.
  - `o_press` and `o_release` are never both high on one channel.
- **Bounce:** any return of `sync2` to `stable` before the count completes resets `cnt` to 0. The glitch produces no output change.
- **Counter:** never exceeds DB_CYCLES-1 and never wraps.
- **Multiple channels:** simultaneous presses on several channels produce simultaneous pulses. No priority or arbitration.
- **Held button:** a button held indefinitely gives one `o_press` only. `o_level` stays 1.

## Timing

- **Reset values:** while `i_reset` = 0, `sync1`, `sync2`, `stable`, `cnt`, `o_level`, `o_press` and `o_release` are all 0. Outputs go low asynchronously on reset assertion.
- **Press latency:** let edge 1 be the first rising edge that samples `i_btn[i]` = 1 into `sync1`, with the input held high. Then:
  - `o_level[i]` and `o_press[i]` rise after edge DB_CYCLES+2.
  - `o_press[i]` falls after edge DB_CYCLES+3.
- **Release latency:** symmetric, with `o_release` in place of `o_press`.
- **Rejection threshold:** a pulse or glitch on `i_btn` lasting fewer than DB_CYCLES consecutive sampled cycles is fully rejected.
- **Reset mid-count:** the count is discarded. After reset deassertion, a still-held button is treated as a new press and yields `o_press` after the full latency from the first post-reset sampling edge.
- **Button held across reset:** yields exactly one `o_press` after reset. There is no suppression.
- **Reset deassertion:** takes effect asynchronously; the first state update is on the next `i_clock` edge. The top level handles synchronous deassertion of `i_reset`.

## Test plan

All scenarios use DB_CYCLES = 4, CNT_W = 3, N_BTN = 3.

1. **Reset:** drive `i_reset` = 0 with `i_btn` = 3'b111 for 10 cycles → all outputs 0 throughout.
2. **Clean press:** raise `i_btn[0]` and hold. → `o_level[0]` = 1 and `o_press` = 3'b001 after edge 6, counted from the first sampling edge. `o_press` is 0 from edge 7 onward. No second pulse over 50 held cycles.
3. **Bounce rejection:** with `stable` = 0, drive `i_btn[1]` as 1,1,1,0,1,1,1,0 repeating. → `o_level[1]` stays 0 and `o_press[1]` is never asserted.
4. **Release:** after scenario 2, drop `i_btn[0]`. → `o_release` = 3'b001 for exactly one cycle, 6 edges after the first low sample. `o_level[0]` = 0 and `o_press[0]` stays 0.
5. **Simultaneous and independent channels:** raise `i_btn[2:0]` = 3'b101 on the same edge. → `o_press` = 3'b101 on a single cycle. Then raise bit 1 three cycles later → `o_press` = 3'b010 exactly three cycles after the first pulse.
6. **Reset mid-count:** press `i_btn[0]`, then pulse `i_reset` low after 3 cycles, then release reset with the button still held. → no pulse before reset. Exactly one `o_press[0]`, 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button synchroniser, debouncer and press/release pulse generator
module button_debouncer #(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] accept;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_chan
            logic [CNT_W-1:0] cnt;

            // A change is accepted only after DB_CYCLES consecutive differing samples.
            assign accept[g] = (sync2[g] != stable[g]) && (cnt == CNT_MAX);

            always_ff @(posedge i_clock or negedge i_reset) begin
                if (!i_reset) begin
                    cnt       <= '0;
                    stable[g] <= 1'b0;
                end else if (sync2[g] == stable[g]) begin
                    cnt <= '0;
                end else if (accept[g]) begin
                    stable[g] <= sync2[g];
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Pulses are registered alongside the level update so they align with o_level.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_press   <= '0;
            o_release <= '0;
        end else begin
            o_press   <= accept & sync2;
            o_release <= accept & ~sync2;
        end
    end

    assign o_level = stable;

endmodule
